riscv_fetch_realign: RTL and testbench
======================================

// Module: riscv_fetch_realign
// PURPOSE
//  Buffers 32-bit word-aligned fetch data from the prefetcher and extracts one instruction per handshake.
//  Instructions may be 16-bit or 32-bit, and a 32-bit one may straddle two words.
//  Sits directly upstream of riscv_compressed_decoder: out_rdata_o feeds its instr_i, out_addr_o is the PC.
//  Flushed on every taken branch/jump/exception by the controller.
// PARAMETERS
//  DEPTH  4  fetch-word entries held (>=2, power of two)
// PORTS
//  clk           in   1   clock, rising edge
//  rst           in   1   asynchronous, active-high reset
//  clear_i       in   1   flush all entries (branch/jump/exception)
//  in_valid_i    in   1   fetch word valid
//  in_ready_o    out  1   entry available; word accepted when in_valid_i && in_ready_o
//  in_addr_i     in   32  fetch address; [1] meaningful only for first word after reset/clear
//  in_rdata_i    in   32  fetch word (little-endian halfwords)
//  out_valid_o   out  1   out_rdata_o/out_addr_o hold a complete instruction
//  out_ready_i   in   1   consumer takes instruction when out_valid_o && out_ready_i
//  out_rdata_o   out  32  instruction; compressed -> {16'h0, hw}
//  out_addr_o    out  32  PC of the instruction, bit0 = 0
// BEHAVIOUR
//  - Reset/clear: count=0, hw offset=0, first_q=1; out_valid_o=0, in_ready_o=1, out_rdata_o=0, out_addr_o=0.
//  - Storage: entries {addr[31:2], rdata}, circular rd/wr pointers, count 0..DEPTH; in_ready_o = count!=DEPTH (registered-state based).
//  - Push: stored addr = {in_addr_i[31:2],2'b00}; if first_q, offset <= in_addr_i[1], first_q <= 0.
//  - Latency: word pushed in cycle N visible on outputs at N+1 (unless bypass, see CONFIGURATION).
//  - Extraction from head H (next N), lo=H[15:0], hi=H[31:16]:
//      off=0, lo[1:0]!=11: out={16'h0,lo}, valid if count>=1; accept -> off=1
//      off=0, lo[1:0]==11: out=H,          valid if count>=1; accept -> pop H, off=0
//      off=1, hi[1:0]!=11: out={16'h0,hi}, valid if count>=1; accept -> pop H, off=0
//      off=1, hi[1:0]==11: out={N[15:0],hi}, valid only if count>=2; accept -> pop H, off=1
//  - out_addr_o = {H.addr[31:2], off, 1'b0}.
//  - Push and pop same cycle: count unchanged; allowed when full only via pop-first? NO: full => in_ready_o=0 regardless of pop.
//  - Pointers wrap mod DEPTH; count never exceeds DEPTH nor underflows.
//  - clear_i has priority: any push/pop that cycle is discarded; outputs return to reset values next cycle.
//  - Reset asserted mid-operation: all state cleared asynchronously; outputs at reset values immediately.
//  - out_rdata_o/out_addr_o stable while out_valid_o && !out_ready_i (no clear).
//  - When out_valid_o=0, out_rdata_o/out_addr_o are don't-care; bench must not check them.
// CONFIGURATION
//  FETCH_REALIGN_BYPASS_EN defined:
//   when count=0, off=0, !first_q, and in_valid_i: out_valid_o=1 same cycle from in_rdata_i/in_addr_i.
//   A 32-bit aligned word accepted on out_ready_i is consumed without being written.
//   A compressed lower half is written, with off<=1 on accept.
//   The first word after reset/clear is never bypassed.
//  Undefined: no combinational in->out path; minimum latency one cycle.
// STRUCTURE
//  - riscv_defines: typedef fetch_entry_t {logic [29:0] addr; logic [31:0] rdata;} and a localparam for the halfword-compressed test (bits[1:0]!=2'b11).
//  - One sub-module riscv_fetch_fifo: generic DEPTH-entry fetch_entry_t FIFO exposing head and head+1 entries.
//  - Realign offset/first_q state and extraction muxing stay in riscv_fetch_realign.
// TESTING
//  - Aligned 32b stream: push 0x00000413@0x80, 0x00100493@0x84 -> out 0x00000413@0x80, then 0x00100493@0x84.
//  - Two compressed in one word: push 0x45014081@0x100 -> out 0x00004081@0x100, then 0x00004501@0x102; count returns to 0.
//  - Straddle: push 0x04134081@0x200 then 0x00130000@0x204:
//     out 0x00004081@0x200, then 0x00000413@0x202 (valid only after second push), then 0x00000013@0x206 (held until third word).
//  - Misaligned branch target: clear_i, then push 0x0001FFFF@0x302 -> first out 0x00000001@0x302; lower half discarded.
//  - Full/backpressure: out_ready_i=0, push DEPTH words -> in_ready_o=0 after 4th.
//     Simultaneous pop+push at full is not accepted; order preserved when drained.
//  - clear_i asserted with in_valid_i and out_ready_i same cycle -> no pop/push, out_valid_o=0 next cycle.
//     Async rst mid-stream -> out_valid_o=0 immediately.

Source files
------------

// File: rtl/riscv_defines.sv
// Shared types and constants for the fetch realignment path.
package riscv_defines;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] rdata;
    } fetch_entry_t;

    // Low two bits of a halfword equal to this mark the start of a 32-bit instruction.
    localparam logic [1:0] Instr32bTag = 2'b11;

    function automatic logic is_compressed(input logic [15:0] hw);
        return hw[1:0] != Instr32bTag;
    endfunction

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Circular FIFO of fetch_entry_t words; exposes the head entry and the one behind it
// so a 32-bit instruction straddling two words can be assembled without popping.
module riscv_fetch_fifo
    import riscv_defines::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear_i,
    input  logic                         push_i,
    input  fetch_entry_t                 wdata_i,
    input  logic                         pop_i,
    output fetch_entry_t                 head_o,
    output fetch_entry_t                 next_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    fetch_entry_t    mem_q [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] nxt_ptr;
    logic            push_ok;
    logic            pop_ok;

    assign push_ok = push_i && (count_q != CntW'(DEPTH)) && !clear_i;
    assign pop_ok  = pop_i && (count_q != '0) && !clear_i;
    assign nxt_ptr = rd_ptr_q + PtrW'(1);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every read that matters.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign next_o  = mem_q[nxt_ptr];
    assign count_o = count_q;

endmodule

// File: rtl/riscv_fetch_realign.sv
// Realigns word fetches into one 16/32-bit instruction per handshake.
// Optional same-cycle bypass from an empty buffer: define FETCH_REALIGN_BYPASS_EN.
module riscv_fetch_realign
    import riscv_defines::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_addr_i,
    input  logic [31:0] in_rdata_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_rdata_o,
    output logic [31:0] out_addr_o
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic            off_q, off_d;
    logic            first_q, first_d;
    fetch_entry_t    head, next, wdata;
    logic [CntW-1:0] count;
    logic            push_en, pop_en;
    logic            bypass;
    logic [31:0]     src_rdata;
    logic [29:0]     src_addr;
    logic [15:0]     lo, hi;
    logic [31:0]     cand_rdata;
    logic            cand_valid;
    logic            fire;
    logic            unused_addr_b0;

    assign unused_addr_b0 = in_addr_i[0];
    assign wdata          = '{addr: in_addr_i[31:2], rdata: in_rdata_i};
    assign in_ready_o     = (count != CntW'(DEPTH));

    riscv_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (clear_i),
        .push_i  (push_en),
        .wdata_i (wdata),
        .pop_i   (pop_en),
        .head_o  (head),
        .next_o  (next),
        .count_o (count)
    );

    // Instruction candidate from the head word, or from the input word when bypassing.
    always_comb begin
        bypass     = 1'b0;
        src_rdata  = head.rdata;
        src_addr   = head.addr;
        cand_valid = (count != '0);
`ifdef FETCH_REALIGN_BYPASS_EN
        bypass = (count == '0) && !off_q && !first_q && in_valid_i;
        if (bypass) begin
            src_rdata  = in_rdata_i;
            src_addr   = in_addr_i[31:2];
            cand_valid = 1'b1;
        end
`endif
        lo         = src_rdata[15:0];
        hi         = src_rdata[31:16];
        cand_rdata = src_rdata;
        if (!off_q) begin
            if (is_compressed(lo)) cand_rdata = {16'h0, lo};
        end else if (is_compressed(hi)) begin
            cand_rdata = {16'h0, hi};
        end else begin
            cand_rdata = {next.rdata[15:0], hi};
            cand_valid = (count >= CntW'(2));
        end
    end

    assign fire        = cand_valid && out_ready_i;
    assign out_valid_o = cand_valid;
    assign out_rdata_o = cand_valid ? cand_rdata : 32'h0;
    assign out_addr_o  = cand_valid ? {src_addr, off_q, 1'b0} : 32'h0;

    always_comb begin
        push_en = in_valid_i && in_ready_o;
        pop_en  = 1'b0;
        off_d   = off_q;
        first_d = first_q;
        if (fire) begin
            if (!off_q) begin
                if (is_compressed(lo)) begin
                    off_d = 1'b1;
                end else if (bypass) begin
                    // Whole aligned word consumed straight from the input; never stored.
                    push_en = 1'b0;
                end else begin
                    pop_en = 1'b1;
                end
            end else begin
                pop_en = 1'b1;
                off_d  = !is_compressed(hi);
            end
        end
        // First word after reset/clear carries the halfword entry point of a branch target.
        if (push_en && first_q) begin
            off_d   = in_addr_i[1];
            first_d = 1'b0;
        end
        if (clear_i) begin
            push_en = 1'b0;
            pop_en  = 1'b0;
            off_d   = 1'b0;
            first_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            off_q   <= 1'b0;
            first_q <= 1'b1;
        end else begin
            off_q   <= off_d;
            first_q <= first_d;
        end
    end

endmodule

// File: tb/tb_riscv_fetch_realign.sv
// Scoreboard bench for riscv_fetch_realign: expected {rdata, addr} pairs are queued with
// the stimulus and compared as the DUT hands instructions over.
module tb_riscv_fetch_realign;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_addr_i;
    logic [31:0] in_rdata_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_rdata_o;
    logic [31:0] out_addr_o;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    riscv_fetch_realign #(
        .DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (clear_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_addr_i   (in_addr_i),
        .in_rdata_i  (in_rdata_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_rdata_o (out_rdata_o),
        .out_addr_o  (out_addr_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Handshakes complete on the next rising edge; inputs are stable at the falling edge.
    always @(negedge clk) begin
        if (!rst && !clear_i && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_out", 64'(out_valid_o), 64'd0);
            end else begin
                check_eq("instr", {out_rdata_o, out_addr_o}, exp_q.pop_front());
            end
        end
    end

    task automatic expect_instr(input logic [31:0] rdata, input logic [31:0] addr);
        exp_q.push_back({rdata, addr});
    endtask

    task automatic push_word(input logic [31:0] addr, input logic [31:0] rdata);
        bit done = 1'b0;
        in_valid_i = 1'b1;
        in_addr_i  = addr;
        in_rdata_i = rdata;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (in_ready_o) done = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid_i = 1'b0;
        if (!done) check_eq("push_timeout", 64'(in_ready_o), 64'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            check_eq("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        @(posedge clk);
        #1;
        clear_i = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        clear_i     = 1'b0;
        in_valid_i  = 1'b0;
        in_addr_i   = '0;
        in_rdata_i  = '0;
        out_ready_i = 1'b1;
        #12;
        check_eq("rst_out_valid", 64'(out_valid_o), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready_o), 64'd1);
        check_eq("rst_out_data", {out_rdata_o, out_addr_o}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Aligned 32-bit stream
        expect_instr(32'h0000_0413, 32'h80);
        expect_instr(32'h0010_0493, 32'h84);
        push_word(32'h80, 32'h0000_0413);
        push_word(32'h84, 32'h0010_0493);
        wait_drain();

        // Two compressed halves in one word
        expect_instr(32'h0000_4081, 32'h100);
        expect_instr(32'h0000_4501, 32'h102);
        push_word(32'h100, 32'h4501_4081);
        wait_drain();
        check_eq("cc_empty", 64'(out_valid_o), 64'd0);

        // Straddling 32-bit instructions
        expect_instr(32'h0000_4081, 32'h200);
        push_word(32'h200, 32'h0413_4081);
        wait_drain();
        check_eq("straddle_wait1", 64'(out_valid_o), 64'd0);
        expect_instr(32'h0000_0413, 32'h202);
        push_word(32'h204, 32'h0013_0000);
        wait_drain();
        check_eq("straddle_wait2", 64'(out_valid_o), 64'd0);
        expect_instr(32'h0000_0013, 32'h206);
        expect_instr(32'h0000_0000, 32'h20A);
        push_word(32'h208, 32'h0000_0000);
        wait_drain();

        // Branch to a halfword-aligned target
        pulse_clear();
        expect_instr(32'h0000_0001, 32'h302);
        push_word(32'h302, 32'h0001_FFFF);
        wait_drain();
        check_eq("misalign_empty", 64'(out_valid_o), 64'd0);

        // Fill to full under backpressure, then pop and push together
        pulse_clear();
        out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_instr(32'h0000_0013 | (32'(i) << 20), 32'h400 + 32'(4 * i));
            push_word(32'h400 + 32'(4 * i), 32'h0000_0013 | (32'(i) << 20));
        end
        check_eq("full_in_ready", 64'(in_ready_o), 64'd0);
        check_eq("full_out_valid", 64'(out_valid_o), 64'd1);
        out_ready_i = 1'b1;
        expect_instr(32'h0040_0013, 32'h410);
        push_word(32'h410, 32'h0040_0013);
        wait_drain();

        // Clear wins over a same-cycle push and pop
        out_ready_i = 1'b0;
        push_word(32'h500, 32'h0000_0413);
        push_word(32'h504, 32'h0000_0493);
        clear_i     = 1'b1;
        in_valid_i  = 1'b1;
        in_addr_i   = 32'h508;
        in_rdata_i  = 32'h0000_0513;
        out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        clear_i    = 1'b0;
        in_valid_i = 1'b0;
        check_eq("clear_out_valid", 64'(out_valid_o), 64'd0);
        check_eq("clear_in_ready", 64'(in_ready_o), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("clear_stays_empty", 64'(out_valid_o), 64'd0);

        // Asynchronous reset mid-stream
        out_ready_i = 1'b0;
        push_word(32'h600, 32'h0000_0413);
        push_word(32'h604, 32'h0000_0493);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_out_valid", 64'(out_valid_o), 64'd0);
        check_eq("arst_in_ready", 64'(in_ready_o), 64'd1);
        check_eq("arst_out_data", {out_rdata_o, out_addr_o}, 64'd0);
        @(posedge clk);
        #1;
        rst         = 1'b0;
        out_ready_i = 1'b1;
        expect_instr(32'h0000_0413, 32'h80);
        push_word(32'h80, 32'h0000_0413);
        wait_drain();
        check_eq("final_empty", 64'(out_valid_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
